branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch lookup is combinational; execute-stage resolution detects
// mispredictions, produces the redirect PC and updates one entry per cycle.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PCF,
    input  logic             ValidE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic             PredTakenE,
    input  logic [WIDTH-1:0] PredTargetE,
    output logic             PredTakenF,
    output logic [WIDTH-1:0] PredTargetF,
    output logic             flushBranch,
    output logic [WIDTH-1:0] PCCorrectE,
    output logic [31:0]      mispredict_count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int unsigned TAG_W   = WIDTH - INDEX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [WIDTH-1:0] target_q [ENTRIES];
    logic [WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [31:0]      mispredict_count_q;
    logic [31:0]      mispredict_count_d;

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]      tag_f;
    logic                  hit_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_W-1:0]      tag_e;
    logic                  hit_e;

    // Fetch lookup: reads registered table only, so same-cycle updates are not visible
    always_comb begin
        idx_f       = PCF[INDEX_BITS+1:2];
        tag_f       = PCF[WIDTH-1:INDEX_BITS+2];
        hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        PredTakenF  = hit_f && ctr_q[idx_f][1];
        PredTargetF = PredTakenF ? target_q[idx_f] : PCF + WIDTH'(4);
    end

    // Misprediction detection and redirect PC for the execute-stage slot
    always_comb begin
        flushBranch = 1'b0;
        if (ValidE) begin
            if (BranchE) begin
                flushBranch = (TakenE != PredTakenE) ||
                              (TakenE && (TargetE != PredTargetE));
            end else begin
                flushBranch = PredTakenE;
            end
        end
        PCCorrectE = (BranchE && TakenE) ? TargetE : PCE + WIDTH'(4);
    end

    // Next-state for the table entry addressed by PCE and the mispredict counter
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        idx_e    = PCE[INDEX_BITS+1:2];
        tag_e    = PCE[WIDTH-1:INDEX_BITS+2];
        hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

        if (ValidE && BranchE) begin
            if (hit_e) begin
                if (TakenE) begin
                    ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                    target_d[idx_e] = TargetE;
                end else begin
                    ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                end
            end else if (TakenE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = TargetE;
                ctr_d[idx_e]    = 2'b10;
            end
        end else if (ValidE && PredTakenE && hit_e) begin
            // Non-branch predicted taken: drop the aliased entry
            valid_d[idx_e] = 1'b0;
        end

        mispredict_count_d = mispredict_count_q;
        if (flushBranch && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // State registers; reset clears valid/ctr/count and discards any same-cycle update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            mispredict_count_q <= 32'd0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a behavioural table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        ValidE, BranchE, TakenE, PredTakenE;
    logic [31:0] PCE, TargetE, PredTargetE;
    logic        PredTakenF, flushBranch;
    logic [31:0] PredTargetF, PCCorrectE, mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.INDEX_BITS(4), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF),
        .ValidE(ValidE), .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE),
        .TargetE(TargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .flushBranch(flushBranch), .PCCorrectE(PCCorrectE),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: 16-entry table addressed by word index, tag is the rest
    bit        m_valid [16];
    bit [31:0] m_tag   [16];
    bit [31:0] m_tgt   [16];
    int        m_ctr   [16];
    bit [31:0] m_cnt;
    bit        model_live = 1'b0;

    function automatic int slot(input bit [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit [31:0] tagof(input bit [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
    endfunction

    function automatic bit m_flush();
        if (!ValidE) return 1'b0;
        if (!BranchE) return PredTakenE;
        if (TakenE != PredTakenE) return 1'b1;
        return TakenE && (TargetE != PredTargetE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update at each rising edge from the E-stage inputs
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_cnt = 0;
        end else begin
            int s;
            s = slot(PCE);
            if (m_flush() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (ValidE && BranchE) begin
                if (m_hit(PCE)) begin
                    if (TakenE) begin
                        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = TargetE;
                    end else begin
                        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (TakenE) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = tagof(PCE);
                    m_tgt[s]   = TargetE;
                    m_ctr[s]   = 2;
                end
            end else if (ValidE && PredTakenE && m_hit(PCE)) begin
                m_valid[s] = 1'b0;
            end
        end
        model_live = 1'b1;
    end

    // Compare every cycle, mid low phase, after the driver has set inputs
    always @(negedge clk) begin
        if (model_live) begin
            bit        e_pt;
            bit [31:0] e_ptg;
            bit        e_fl;
            #2;
            e_pt  = m_hit(PCF) && (m_ctr[slot(PCF)] >= 2);
            e_ptg = e_pt ? m_tgt[slot(PCF)] : PCF + 32'd4;
            e_fl  = m_flush();
            chk("m_PredTakenF", 32'(PredTakenF), 32'(e_pt));
            chk("m_PredTargetF", PredTargetF, e_ptg);
            chk("m_flushBranch", 32'(flushBranch), 32'(e_fl));
            if (e_fl) chk("m_PCCorrectE", PCCorrectE, (BranchE && TakenE) ? TargetE : PCE + 32'd4);
            chk("m_count", mispredict_count, m_cnt);
        end
    end

    // Apply one cycle of inputs at the falling edge; return once outputs have settled
    task automatic drive(input bit r, input bit [31:0] pcf, input bit v, input bit b,
                         input bit t, input bit [31:0] pce, input bit [31:0] tgt,
                         input bit pt, input bit [31:0] ptg);
        @(negedge clk);
        rst_n = r; PCF = pcf; ValidE = v; BranchE = b; TakenE = t;
        PCE = pce; TargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
        #3;
    endtask

    task automatic idle(input bit [31:0] pcf);
        drive(1, pcf, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; PCF = 32'h100; ValidE = 0; BranchE = 0; TakenE = 0;
        PCE = 0; TargetE = 0; PredTakenE = 0; PredTargetE = 0;

        // Reset: no prediction, bubble never flushes
        drive(0, 32'h100, 0, 1, 1, 32'h100, 32'h80, 1, 32'h80);
        chk("rst_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("rst_PredTargetF", PredTargetF, 32'h104);
        chk("rst_bubble_flush", 32'(flushBranch), 32'h0);
        // Allocation coinciding with reset is discarded
        drive(0, 32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
        idle(32'h100);
        chk("rst_prio_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("rst_prio_count", mispredict_count, 32'h0);

        // Allocate taken branch at 0x100 -> 0x80
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
        chk("alloc_flush", 32'(flushBranch), 32'h1);
        chk("alloc_PCCorrectE", PCCorrectE, 32'h80);
        idle(32'h100);
        chk("alloc_PredTakenF", 32'(PredTakenF), 32'h1);
        chk("alloc_PredTargetF", PredTargetF, 32'h80);
        chk("alloc_count", mispredict_count, 32'h1);

        // Two not-taken resolutions: 10 -> 01 -> 00
        drive(1, 32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80);
        chk("nt1_PCCorrectE", PCCorrectE, 32'h104);
        drive(1, 32'h100, 1, 1, 0, 32'h100, 32'h80, 0, 32'h104);
        chk("nt2_flush", 32'(flushBranch), 32'h0);
        idle(32'h100);
        chk("nt_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("nt_count", mispredict_count, 32'h2);

        // Taken x4: 00 -> 01 -> 10 -> 11 -> 11
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h80, 1, 32'h80);
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h80, 1, 32'h80);
        // One not-taken from saturated 11 still leaves a taken prediction
        drive(1, 32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80);
        idle(32'h100);
        chk("sat_PredTakenF", 32'(PredTakenF), 32'h1);
        chk("sat_count", mispredict_count, 32'h5);

        // Target change on a correctly predicted direction
        drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h90, 1, 32'h80);
        chk("tgt_flush", 32'(flushBranch), 32'h1);
        chk("tgt_PCCorrectE", PCCorrectE, 32'h90);
        idle(32'h100);
        chk("tgt_PredTargetF", PredTargetF, 32'h90);

        // Alias on same index, then invalidate via non-branch predicted taken
        idle(32'h140);
        chk("alias_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("alias_PredTargetF", PredTargetF, 32'h144);
        drive(1, 32'h100, 1, 0, 0, 32'h100, 32'h90, 1, 32'h90);
        chk("inval_flush", 32'(flushBranch), 32'h1);
        chk("inval_PCCorrectE", PCCorrectE, 32'h104);
        idle(32'h100);
        chk("inval_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("inval_count", mispredict_count, 32'h7);

        // Non-branch with a different tag leaves the entry alone
        drive(1, 32'h200, 1, 1, 1, 32'h200, 32'h300, 0, 32'h204);
        drive(1, 32'h200, 1, 0, 0, 32'h140, 32'h0, 1, 32'h300);
        idle(32'h200);
        chk("keep_PredTargetF", PredTargetF, 32'h300);

        // Not-taken miss does not allocate
        drive(1, 32'h204, 1, 1, 0, 32'h204, 32'h500, 0, 32'h208);
        idle(32'h204);
        chk("ntmiss_PredTakenF", 32'(PredTakenF), 32'h0);

        // Same-cycle lookup sees pre-update contents
        drive(1, 32'h208, 1, 1, 1, 32'h208, 32'h400, 0, 32'h20C);
        chk("bypass_PredTakenF", 32'(PredTakenF), 32'h0);
        chk("bypass_PredTargetF", PredTargetF, 32'h20C);
        idle(32'h208);
        chk("bypass_next_PredTargetF", PredTargetF, 32'h400);
        chk("bypass_count", mispredict_count, 32'd10);

        // Bubbles never flush
        drive(1, 32'h208, 0, 1, 1, 32'h208, 32'h999, 0, 32'h0);
        chk("bubble_br_flush", 32'(flushBranch), 32'h0);
        drive(1, 32'h208, 0, 0, 0, 32'h100, 32'h0, 1, 32'h0);
        chk("bubble_nb_flush", 32'(flushBranch), 32'h0);

        // Counter saturation: preload near all-ones, then keep mispredicting
        idle(32'h0);
        force dut.mispredict_count_d = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        m_cnt = 32'hFFFF_FFFE;
        release dut.mispredict_count_d;
        drive(1, 32'h0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h0);
        drive(1, 32'h0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h0);
        chk("cnt_reach_max", mispredict_count, 32'hFFFF_FFFF);
        drive(1, 32'h0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h0);
        idle(32'h0);
        chk("cnt_hold_max", mispredict_count, 32'hFFFF_FFFF);

        idle(32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
